// File: rtl/cla_pipe_adder_if.sv
// Handshake and operand/result bundle for the pipelined carry look-ahead adder.
// master drives operands and out_ready; slave is the adder.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, a, b, ci, op, out_ready,
    input  in_ready, out_valid, sum, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, op, out_ready,
    output in_ready, out_valid, sum, co, ovf
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined add/subtract built from 4-bit carry look-ahead groups; each stage
// resolves GPS groups, so latency is WIDTH/(4*GPS) cycles with full throughput.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int GPS   = 2
) (
  input logic              clk,
  input logic              reset,
  cla_pipe_adder_if.slave  bus
);
  localparam int L  = WIDTH / (4 * GPS);
  localparam int NG = WIDTH / 4;

  // c_msb is the carry into the top bit, only meaningful once the top group is resolved.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             c_msb;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t stage_q [L];
  stage_t stage_d [L];
  logic   stall;

  // Returns {carry into bit 3, group carry-out, 4-bit sum}.
  function automatic logic [5:0] cla4(input logic [3:0] a4, input logic [3:0] b4,
                                      input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a4 & b4;
    p    = a4 | b4;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[3], c[4], a4 ^ b4 ^ c[3:0]};
  endfunction

  always_comb begin
    stage_t     cur;
    logic [5:0] r;
    int         gi;
    stall = stage_q[L-1].valid && !bus.out_ready;
    for (int k = 0; k < L; k++) begin
      if (k == 0) begin
        // Subtract enters as a + ~b + ~borrow, so later stages only ever add.
        cur.valid = bus.in_valid;
        cur.carry = bus.ci ^ bus.op;
        cur.c_msb = 1'b0;
        cur.sum   = '0;
        cur.a     = bus.a;
        cur.b     = bus.b ^ {WIDTH{bus.op}};
      end else begin
        cur = stage_q[k-1];
      end
      for (int g = 0; g < GPS; g++) begin
        gi = k * GPS + g;
        r  = cla4(cur.a[gi*4 +: 4], cur.b[gi*4 +: 4], cur.carry);
        cur.sum[gi*4 +: 4] = r[3:0];
        cur.carry          = r[4];
        if (gi == NG - 1) begin
          cur.c_msb = r[5];
        end
      end
      stage_d[k] = stall ? stage_q[k] : cur;
    end
  end

  // NOTE: the datapath is reset along with the valid bits so sum/co/ovf read 0 during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < L; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign bus.in_ready  = !stall;
  assign bus.out_valid = stage_q[L-1].valid;
  assign bus.sum       = stage_q[L-1].sum;
  assign bus.co        = stage_q[L-1].carry;
  assign bus.ovf       = stage_q[L-1].carry ^ stage_q[L-1].c_msb;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: the driver queues expected results on accept,
// an independent monitor pops and compares on every output handshake.
module tb_cla_pipe_adder;
  localparam int WIDTH = 32;
  localparam int GPS   = 2;
  localparam int L     = 4;

  typedef struct packed {
    logic [31:0] sum;
    logic        co;
    logic        ovf;
  } res_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   rdy_mode = 0;
  int   rdy_cnt  = 0;
  res_t exp_q[$];
  res_t held;
  logic held_v = 1'b0;

  cla_pipe_adder_if #(.WIDTH(WIDTH)) bus();

  cla_pipe_adder #(.WIDTH(WIDTH), .GPS(GPS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Reference model written from the arithmetic definition, not the carry chain.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic op);
    logic [32:0] full;
    res_t        r;
    if (!op) full = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    else     full = {1'b0, a} + {1'b0, ~b} + {32'd0, !ci};
    r.sum = full[31:0];
    r.co  = full[32];
    if (!op) r.ovf = (a[31] == b[31]) && (r.sum[31] != a[31]);
    else     r.ovf = (a[31] != b[31]) && (r.sum[31] != a[31]);
    return r;
  endfunction

  // Consumer side: always ready, random, or scripted stall on cycles 5..7.
  always @(negedge clk) begin
    if (rdy_mode != 2) rdy_cnt = 0;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(3) != 0);
      default: begin
        rdy_cnt++;
        bus.out_ready = !(rdy_cnt >= 5 && rdy_cnt <= 7);
      end
    endcase
  end

  // Monitor: handshake rule, stall stability, and scoreboard compare.
  always @(negedge clk) begin
    res_t r;
    #2;
    if (!reset) begin
      check("in_ready_vs_stall", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
      if (held_v) begin
        check("stall_valid_hold", 64'(bus.out_valid), 64'(1'b1));
        check("stall_data_hold", 64'({bus.sum, bus.co, bus.ovf}), 64'(held));
      end
      held_v = bus.out_valid && !bus.out_ready;
      held   = {bus.sum, bus.co, bus.ovf};
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got %h with nothing outstanding",
                   {bus.sum, bus.co, bus.ovf});
        end else begin
          r = exp_q.pop_front();
          check("result", 64'({bus.sum, bus.co, bus.ovf}), 64'(r));
        end
      end
    end else begin
      held_v = 1'b0;
    end
  end

  // Called just after a negedge; returns just after the negedge following the accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ci,
                      input logic op, input res_t exp, input int gap);
    int budget;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.ci       = ci;
    bus.op       = op;
    budget       = 0;
    #1;
    while (!bus.in_ready) begin
      @(negedge clk);
      #1;
      budget++;
      if (budget > 100) begin
        fail_now("accept_timeout");
        break;
      end
    end
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Edges from accept (inclusive) until out_valid shows, on an otherwise empty pipe.
  task automatic check_latency(input string name);
    int cnt;
    #1;
    cnt = 1;
    while (!bus.out_valid && cnt < 20) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    check(name, 64'(cnt), 64'(L));
    @(negedge clk);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 2000) fail_now("drain_timeout");
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(1'b0));
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1'b1));
    check({tag, "_sum"}, 64'(bus.sum), 64'(32'h0));
    check({tag, "_co"}, 64'(bus.co), 64'(1'b0));
    check({tag, "_ovf"}, 64'(bus.ovf), 64'(1'b0));
  endtask

  logic [31:0] st_a [8] = '{32'h1, 32'h10, 32'hFFFFFFFF, 32'h100, 32'h0,
                            32'h80000000, 32'h7FFFFFFF, 32'h10};
  logic [31:0] st_b [8] = '{32'h2, 32'h20, 32'hFFFFFFFF, 32'h1, 32'h1,
                            32'h80000000, 32'hFFFFFFFF, 32'h8};
  logic        st_c [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        st_o [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  res_t        st_e [8] = '{{32'h3, 1'b0, 1'b0}, {32'h31, 1'b0, 1'b0},
                            {32'hFFFFFFFF, 1'b1, 1'b0}, {32'hFF, 1'b1, 1'b0},
                            {32'hFFFFFFFF, 1'b0, 1'b0}, {32'h0, 1'b1, 1'b1},
                            {32'h80000000, 1'b0, 1'b1}, {32'h7, 1'b1, 1'b0}};

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic        ro;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.ci       = 1'b0;
    bus.op       = 1'b0;

    #12;
    check_reset_outputs("reset_init");
    @(negedge clk);
    reset = 1'b0;

    send(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, '{32'h0, 1'b1, 1'b0}, 0);
    check_latency("latency_first");
    drain();
    send(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, '{32'h80000000, 1'b0, 1'b1}, 0);
    send(32'h80000000, 32'h1, 1'b0, 1'b1, '{32'h7FFFFFFF, 1'b1, 1'b1}, 0);
    send(32'h5, 32'h7, 1'b1, 1'b1, '{32'hFFFFFFFD, 1'b0, 1'b0}, 0);
    send(32'h12345678, 32'h11111111, 1'b1, 1'b0, '{32'h2345678A, 1'b0, 1'b0}, 0);
    send(32'h0, 32'h0, 1'b0, 1'b1, '{32'h0, 1'b1, 1'b0}, 0);
    drain();

    rdy_mode = 2;
    for (int i = 0; i < 8; i++) send(st_a[i], st_b[i], st_c[i], st_o[i], st_e[i], 0);
    drain();
    rdy_mode = 0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) send(32'h100 + 32'(i), 32'h1, 1'b0, 1'b0, '{32'hDEAD, 1'b1, 1'b1}, 0);
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_inflight");
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    send(32'h1, 32'h1, 1'b0, 1'b0, '{32'h2, 1'b0, 1'b0}, 0);
    check_latency("latency_after_reset");
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1));
      ro = 1'($urandom_range(1));
      if ($urandom_range(7) == 0) ra = 32'h7FFFFFFF;
      if ($urandom_range(7) == 0) rb = 32'h80000000;
      send(ra, rb, rc, ro, model(ra, rb, rc, ro), ($urandom_range(3) == 0) ? 1 : 0);
    end
    drain();
    rdy_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter GPS, default 2, giving the number of 4-bit carry look-ahead groups resolved per pipeline stage.
REQ-003 WIDTH SHALL be a multiple of 4*GPS; latency L = WIDTH/(4*GPS) stages (L=4 at defaults); other values are unsupported.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  operand set offered.
REQ-008 in_ready  output  1  block accepts the offered operand set this cycle.
REQ-009 a  input  WIDTH  operand A.
REQ-010 b  input  WIDTH  operand B.
REQ-011 ci  input  1  carry-in for add; borrow-in for subtract.
REQ-012 op  input  1  0 = add, 1 = subtract.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  consumer takes the result this cycle.
REQ-015 sum  output  WIDTH  result.
REQ-016 co  output  1  carry-out of the MSB.
REQ-017 ovf  output  1  two's-complement overflow.

Function
REQ-018 Accept SHALL occur when in_valid && in_ready.
REQ-019 Add (op=0) SHALL compute a + b + ci.
REQ-020 Subtract (op=1) SHALL compute a + ~b + ~ci, i.e. a - b - ci; co=1 then means no borrow.
REQ-021 Each 4-bit group SHALL use generate g=a&b and propagate p=a|b look-ahead carries.
REQ-022 Each stage SHALL resolve GPS groups, rippling the group carry-out between groups.
REQ-023 Stage k SHALL register the resolved sum bits, the inter-stage carry and the still-unprocessed upper operand bits (pre-inverted b for subtract).
REQ-024 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-025 Stall SHALL be defined as out_valid && !out_ready.
REQ-026 in_ready SHALL equal !stall.
REQ-027 On stall all stages and valid bits SHALL hold; otherwise all stages SHALL advance one stage.
REQ-028 A per-stage valid bit SHALL travel with the data; bubbles SHALL be permitted and preserved.
REQ-029 Without stall, an accept at edge n SHALL present out_valid with the result after edge n+L-1.
REQ-030 Full throughput: one accept and one result per cycle SHALL be sustained while out_ready=1.
REQ-031 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-032 Simultaneous accept and output handshake in one cycle SHALL both take effect.
REQ-033 sum, co and ovf SHALL be stable while out_valid && !out_ready.
REQ-034 sum, co and ovf are don't-care when out_valid=0.
REQ-035 Wrap-around SHALL be modulo 2^WIDTH, with the lost bit reported on co.

Reset
REQ-036 Asserting reset SHALL immediately clear all stage valid bits, making out_valid=0.
REQ-037 Asserting reset SHALL immediately force in_ready=1 and sum=0, co=0, ovf=0.
REQ-038 Operations in flight at reset SHALL be discarded.
REQ-039 No output handshake SHALL occur while reset is asserted.
REQ-040 On the first edge after reset deassertion, the block SHALL be able to accept.

Verification (WIDTH=32, GPS=2, L=4)
REQ-041 Add 0xFFFFFFFF + 0x00000001, ci=0 -> sum=0x00000000, co=1, ovf=0, out_valid 4 cycles after accept.
REQ-042 Add 0x7FFFFFFF + 0x00000001, ci=0 -> sum=0x80000000, co=0, ovf=1; subtract 0x80000000 - 0x00000001, ci=0 -> sum=0x7FFFFFFF, co=1, ovf=1.
REQ-043 Subtract 0x00000005 - 0x00000007, ci=1 -> sum=0xFFFFFFFD, co=0, ovf=0.
REQ-044 Stream of 8 accepts with out_ready low for cycles 5-7 -> in_ready low exactly while stalled, all 8 results exact and in order, outputs stable during stall.
REQ-045 Randomized a/b/ci/op with random in_valid/out_ready for 10^4 operations -> every result matches a reference model on sum, co and ovf.
REQ-046 Reset asserted with 3 operations in flight -> out_valid=0 immediately, none of the 3 ever emerges, and the next accepted add 0x1+0x1 gives 0x2 after 4 cycles.
